// File: rtl/arithmetic_logic_unit.sv
// Registered ALU: arithmetic group built on one adder (A + Y + cin), bitwise logic group,
// and V/C/Z/N flags, all captured together one cycle after the operands are presented.
module arithmetic_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       G,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             V,
  output logic             C,
  output logic             Z,
  output logic             N
);

  logic [WIDTH-1:0] y_sel;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_res;

  logic [WIDTH-1:0] result_next, result_reg;
  logic             v_next, v_reg;
  logic             c_next, c_reg;
  logic             z_reg, n_reg;

  // Second adder operand; together with cin this encodes every arithmetic code.
  always_comb begin
    y_sel = '0;
    case (G[2:1])
      2'b00: y_sel = '0;
      2'b01: y_sel = B;
      2'b10: y_sel = ~B;
      2'b11: y_sel = '1;
      default: y_sel = '0;
    endcase
  end

  assign cin = G[0];
  assign sum = {1'b0, A} + {1'b0, y_sel} + {{WIDTH{1'b0}}, cin};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_logic
      assign logic_res[gi] = (G[2:1] == 2'b00) ? (A[gi] & B[gi]) :
                             (G[2:1] == 2'b01) ? (A[gi] | B[gi]) :
                             (G[2:1] == 2'b10) ? (A[gi] ^ B[gi]) :
                                                 ~A[gi];
    end
  endgenerate

  always_comb begin
    result_next = sum[WIDTH-1:0];
    c_next      = sum[WIDTH];
    v_next      = (A[WIDTH-1] == y_sel[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    if (G[3]) begin
      result_next = logic_res;
      c_next      = 1'b0;
      v_next      = 1'b0;
    end else if (G[2:0] == 3'b111) begin
      // A + all-ones + 1 would wrap back to A with a spurious carry; report a clean pass.
      result_next = A;
      c_next      = 1'b0;
      v_next      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg <= '0;
      v_reg      <= 1'b0;
      c_reg      <= 1'b0;
      z_reg      <= 1'b1;
      n_reg      <= 1'b0;
    end else begin
      result_reg <= result_next;
      v_reg      <= v_next;
      c_reg      <= c_next;
      z_reg      <= (result_next == '0);
      n_reg      <= result_next[WIDTH-1];
    end
  end

  assign ALU_Result = result_reg;
  assign V          = v_reg;
  assign C          = c_reg;
  assign Z          = z_reg;
  assign N          = n_reg;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Self-checking bench for arithmetic_logic_unit: directed vectors, reset behaviour,
// input isolation between edges, and randomized operations against an integer model.
module tb_arithmetic_logic_unit;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [3:0]       G;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] ALU_Result;
  logic             V, C, Z, N;

  int tests_run;
  int tests_failed;

  arithmetic_logic_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .G         (G),
    .A         (A),
    .B         (B),
    .ALU_Result(ALU_Result),
    .V         (V),
    .C         (C),
    .Z         (Z),
    .N         (N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values.
  function automatic void model(input logic [3:0] g, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic c, output logic v);
    int yv, s, sa, sy, ss;
    res = 8'h00; c = 1'b0; v = 1'b0;
    if (!g[3]) begin
      case (g[2:1])
        2'd0:    yv = 0;
        2'd1:    yv = int'(b);
        2'd2:    yv = 255 - int'(b);
        default: yv = 255;
      endcase
      s   = int'(a) + yv + int'(g[0]);
      res = 8'(s % 256);
      c   = (s > 255);
      sa  = (a > 127) ? int'(a) - 256 : int'(a);
      sy  = (yv > 127) ? yv - 256 : yv;
      ss  = sa + sy + int'(g[0]);
      v   = (ss > 127) || (ss < -128);
      if (g == 4'd7) begin
        res = a; c = 1'b0; v = 1'b0;
      end
    end else begin
      case (g[2:1])
        2'd0:    res = a & b;
        2'd1:    res = a | b;
        2'd2:    res = a ^ b;
        default: res = ~a;
      endcase
    end
  endfunction

  task automatic check_outputs(input string tag, input logic [7:0] res, input logic c, input logic v);
    check({tag, ".res"}, ALU_Result, res);
    check({tag, ".c"}, C, c);
    check({tag, ".v"}, V, v);
    check({tag, ".z"}, Z, (res == 8'h00));
    check({tag, ".n"}, N, res[7]);
  endtask

  task automatic drive_op(input logic [3:0] g, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    G = g; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] g;
    logic [7:0] a, b, res;
    logic       c, v;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] m_res, prev_res;
    logic       m_c, m_v;
    string      tag;

    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; G = 4'd2; A = 8'h12; B = 8'h34;

    // Reset values hold across clock edges while rst is high.
    #22;
    check_outputs("reset_hold", 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    vecs = '{
      '{4'd5,  8'h0A, 8'h0A, 8'h00, 1'b1, 1'b0}, '{4'd4,  8'h0A, 8'h0A, 8'hFF, 1'b0, 1'b0},
      '{4'd6,  8'h0A, 8'h0A, 8'h09, 1'b1, 1'b0}, '{4'd1,  8'hFF, 8'h0A, 8'h00, 1'b1, 1'b0},
      '{4'd2,  8'hFF, 8'h0A, 8'h09, 1'b1, 1'b0}, '{4'd4,  8'hFF, 8'h0A, 8'hF4, 1'b1, 1'b0},
      '{4'd6,  8'hFF, 8'h0A, 8'hFE, 1'b1, 1'b0}, '{4'd2,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1},
      '{4'd3,  8'h80, 8'h80, 8'h01, 1'b1, 1'b1}, '{4'd5,  8'h80, 8'h80, 8'h00, 1'b1, 1'b0},
      '{4'd6,  8'h80, 8'h80, 8'h7F, 1'b1, 1'b1}, '{4'd7,  8'h80, 8'h80, 8'h80, 1'b0, 1'b0},
      '{4'd1,  8'h7F, 8'h7F, 8'h80, 1'b0, 1'b1}, '{4'd2,  8'h7F, 8'h7F, 8'hFE, 1'b0, 1'b1},
      '{4'd0,  8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0}, '{4'd8,  8'hFF, 8'h0A, 8'h0A, 1'b0, 1'b0},
      '{4'd9,  8'hFF, 8'h0A, 8'h0A, 1'b0, 1'b0}, '{4'd10, 8'hFF, 8'h0A, 8'hFF, 1'b0, 1'b0},
      '{4'd11, 8'hFF, 8'h0A, 8'hFF, 1'b0, 1'b0}, '{4'd12, 8'hFF, 8'h0A, 8'hF5, 1'b0, 1'b0},
      '{4'd13, 8'hFF, 8'h0A, 8'hF5, 1'b0, 1'b0}, '{4'd14, 8'hFF, 8'h0A, 8'h00, 1'b0, 1'b0},
      '{4'd15, 8'hFF, 8'h0A, 8'h00, 1'b0, 1'b0}
    };

    foreach (vecs[i]) begin
      drive_op(vecs[i].g, vecs[i].a, vecs[i].b);
      tag = $sformatf("dir%0d_g%0d", i, vecs[i].g);
      check_outputs(tag, vecs[i].res, vecs[i].c, vecs[i].v);
    end

    // Inputs changed between edges must not reach the outputs.
    drive_op(4'd2, 8'hFF, 8'h0A);
    #2;
    G = 4'd14; A = 8'h00; B = 8'h55;
    #2;
    check_outputs("hold_between_edges", 8'h09, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle clears a non-zero result immediately.
    drive_op(4'd2, 8'hFF, 8'h0A);
    check_outputs("pre_async_rst", 8'h09, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 8'h00, 1'b0, 1'b0);
    G = 4'd12; A = 8'hFF; B = 8'h0A;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_rst_load", 8'hF5, 1'b0, 1'b0);

    // Randomized operations against the integer model.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] rg;
      logic [7:0] ra, rb;
      rg = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 10 == 0) ra = 8'h80;
      if (i % 10 == 1) rb = 8'hFF;
      if (i % 10 == 2) ra = 8'h7F;
      drive_op(rg, ra, rb);
      model(rg, ra, rb, m_res, m_c, m_v);
      prev_res = m_res;
      tag = $sformatf("rnd%0d_g%0d_a%02h_b%02h", i, rg, ra, rb);
      check_outputs(tag, prev_res, m_c, m_v);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
